// File: rtl/vga_pkg.sv
// Shared VGA timing constants, RGB12 field layout and coordinate width for
// the 640x480@60 Hz display path.
`timescale 1ns/1ps
package vga_pkg;

   localparam int COORD_W = 10;

   // Default 640x480@60 Hz timing, in pixels and lines
   localparam int DEF_CLK_DIV = 4;
   localparam int DEF_H_VIS   = 640;
   localparam int DEF_H_FP    = 16;
   localparam int DEF_H_SYNC  = 96;
   localparam int DEF_H_BP    = 48;
   localparam int DEF_V_VIS   = 480;
   localparam int DEF_V_FP    = 10;
   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BP    = 33;

   localparam int H_TOTAL      = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL      = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
   localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

   // RGB12 is packed {R[11:8], G[7:4], B[3:0]}
   localparam int RGB_FIELD_W = 4;
   localparam int RGB_R_LSB   = 8;
   localparam int RGB_G_LSB   = 4;
   localparam int RGB_B_LSB   = 0;

   typedef struct packed {
      logic [RGB_FIELD_W-1:0] r;
      logic [RGB_FIELD_W-1:0] g;
      logic [RGB_FIELD_W-1:0] b;
   } rgb12_t;

   function automatic logic in_span(input logic [COORD_W-1:0] c,
                                    input int lo, input int hi);
      return (int'(c) >= lo) && (int'(c) <= hi);
   endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider producing a one-clk enable every CLK_DIV clocks; shared by
// the VGA pixel path and slower game-tick logic.
`timescale 1ns/1ps
module pixel_tick_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] div_cnt;
   logic             div_last;

   assign div_last = (div_cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (div_last) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   // Reset leaves div_cnt at 0, so the tick stays low until CLK_DIV-1
   assign tick = div_last;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel tick, h/v beam counters, registered sync and
// blanked colour. Define VGA_PIPE2_EN for a second sync/video_on stage.
`timescale 1ns/1ps
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int H_VIS   = DEF_H_VIS,
   parameter int H_FP    = DEF_H_FP,
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BP    = DEF_H_BP,
   parameter int V_VIS   = DEF_V_VIS,
   parameter int V_FP    = DEF_V_FP,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BP    = DEF_V_BP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [11:0]        rgb_in,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               video_on,
   output logic               pix_tick,
   output logic               frame_start,
   output logic [3:0]         vgaRED,
   output logic [3:0]         vgaGREEN,
   output logic [3:0]         vgaBLUE,
   output logic               Hsync,
   output logic               Vsync
);

   localparam int LINE_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HS_FIRST    = H_VIS + H_FP;
   localparam int HS_LAST     = HS_FIRST + H_SYNC - 1;
   localparam int VS_FIRST    = V_VIS + V_FP;
   localparam int VS_LAST     = VS_FIRST + V_SYNC - 1;

   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic               h_end;
   logic               v_end;
   logic               hs_now;
   logic               vs_now;
   rgb12_t             rgb_src;

   pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (pix_tick)
   );

   assign h_end = (h_cnt == COORD_W'(LINE_LEN - 1));
   assign v_end = (v_cnt == COORD_W'(FRAME_LINES - 1));

   // Beam position, advanced once per pixel period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_tick) begin
         if (h_end) begin
            h_cnt <= '0;
            v_cnt <= v_end ? '0 : v_cnt + COORD_W'(1);
         end else begin
            h_cnt <= h_cnt + COORD_W'(1);
         end
      end
   end

   assign pixel_x     = h_cnt;
   assign pixel_y     = v_cnt;
   assign video_on    = (h_cnt < COORD_W'(H_VIS)) && (v_cnt < COORD_W'(V_VIS));
   assign frame_start = pix_tick && h_end && v_end;

   assign hs_now  = ~in_span(h_cnt, HS_FIRST, HS_LAST);
   assign vs_now  = ~in_span(v_cnt, VS_FIRST, VS_LAST);
   assign rgb_src = rgb12_t'(rgb_in);

`ifdef VGA_PIPE2_EN
   logic   hsync_p1;
   logic   vsync_p1;
   logic   von_p1;
   logic   hsync_p2;
   logic   vsync_p2;
   rgb12_t rgb_p2;

   // Stage 1: beam-derived sync and visibility of the current coordinate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_p1 <= 1'b1;
         vsync_p1 <= 1'b1;
         von_p1   <= 1'b0;
      end else if (pix_tick) begin
         hsync_p1 <= hs_now;
         vsync_p1 <= vs_now;
         von_p1   <= video_on;
      end
   end

   // Stage 2: rgb_in now belongs to the coordinate held in stage 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_p2 <= 1'b1;
         vsync_p2 <= 1'b1;
         rgb_p2   <= '0;
      end else if (pix_tick) begin
         hsync_p2 <= hsync_p1;
         vsync_p2 <= vsync_p1;
         rgb_p2   <= von_p1 ? rgb_src : '0;
      end
   end

   assign Hsync    = hsync_p2;
   assign Vsync    = vsync_p2;
   assign vgaRED   = rgb_p2.r;
   assign vgaGREEN = rgb_p2.g;
   assign vgaBLUE  = rgb_p2.b;
`else
   logic   hsync_p1;
   logic   vsync_p1;
   rgb12_t rgb_p1;

   // Stage 1: sync and blanked colour for the pre-increment coordinate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_p1 <= 1'b1;
         vsync_p1 <= 1'b1;
         rgb_p1   <= '0;
      end else if (pix_tick) begin
         hsync_p1 <= hs_now;
         vsync_p1 <= vs_now;
         rgb_p1   <= video_on ? rgb_src : '0;
      end
   end

   assign Hsync    = hsync_p1;
   assign Vsync    = vsync_p1;
   assign vgaRED   = rgb_p1.r;
   assign vgaGREEN = rgb_p1.g;
   assign vgaBLUE  = rgb_p1.b;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a reduced raster so several whole frames and a
// mid-frame reset fit in a short run; outputs are scored against a beam model.
`timescale 1ns/1ps
module tb_vga_sync_gen;
   import vga_pkg::*;

   localparam int CLK_DIV = 4;
   localparam int H_VIS = 16, H_FP = 4, H_SYNC = 6, H_BP = 4;
   localparam int V_VIS = 10, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int FRAME_CLKS = HT * VT * CLK_DIV;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [11:0]        rgb_in = 12'h000;
   logic [COORD_W-1:0] pixel_x, pixel_y;
   logic               video_on, pix_tick, frame_start;
   logic [3:0]         vgaRED, vgaGREEN, vgaBLUE;
   logic               Hsync, Vsync;

   vga_sync_gen #(
      .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .rst(rst), .rgb_in(rgb_in),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .pix_tick(pix_tick), .frame_start(frame_start),
      .vgaRED(vgaRED), .vgaGREEN(vgaGREEN), .vgaBLUE(vgaBLUE),
      .Hsync(Hsync), .Vsync(Vsync)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   n = 0;      // clk edges since reset release
   int   mode = 0;   // 0 random colour, 1 white, 2 F0A

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t, n=%0d)", name, act, req, $time, n);
      end
   endtask

   // Output the spec's raster rules give for pixel index k (from frame origin)
   function automatic exp_t beam(input int k, input logic [11:0] rgb);
      exp_t e;
      int   h, v;
      h = k % HT;
      v = (k / HT) % VT;
      e.hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
      e.vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
      e.rgb = (h < H_VIS && v < V_VIS) ? rgb : 12'h000;
      return e;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) n <= 0;
      else     n <= n + 1;
   end

   // Stimulus: new colour each pixel period, expected response queued
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && (n % CLK_DIV) == CLK_DIV - 1) begin
            case (mode)
               1:       rgb_in = 12'hFFF;
               2:       rgb_in = 12'hF0A;
               default: rgb_in = 12'($urandom_range(0, 4095));
            endcase
`ifdef VGA_PIPE2_EN
            if (n / CLK_DIV == 0) e = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
            else                  e = beam(n / CLK_DIV - 1, rgb_in);
`else
            e = beam(n / CLK_DIV, rgb_in);
`endif
            q.push_back(e);
         end
      end
   end

   // Monitor: retire one expectation per capture edge, check every cycle
   always @(negedge clk) begin
      int k, x, y;
      logic tk;
      if (rst) begin
         cur = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
         chk("rst_pixel_x", int'(pixel_x), 0);
         chk("rst_pixel_y", int'(pixel_y), 0);
         chk("rst_pix_tick", int'(pix_tick), 0);
         chk("rst_frame_start", int'(frame_start), 0);
      end else begin
         if (n > 0 && (n % CLK_DIV) == 0) begin
            if (q.size() == 0) chk("queue_underflow", 1, 0);
            else               cur = q.pop_front();
         end
         k  = n / CLK_DIV;
         x  = k % HT;
         y  = (k / HT) % VT;
         tk = ((n % CLK_DIV) == CLK_DIV - 1);
         chk("pixel_x", int'(pixel_x), x);
         chk("pixel_y", int'(pixel_y), y);
         chk("video_on", int'(video_on), int'(x < H_VIS && y < V_VIS));
         chk("pix_tick", int'(pix_tick), int'(tk));
         chk("frame_start", int'(frame_start), int'(tk && x == HT - 1 && y == VT - 1));
      end
      chk("Hsync", int'(Hsync), int'(cur.hs));
      chk("Vsync", int'(Vsync), int'(cur.vs));
      chk("rgb", int'({vgaRED, vgaGREEN, vgaBLUE}), int'(cur.rgb));
   end

   initial begin
      int target;
      bit hit;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;

      mode = 1;
      repeat (HT * CLK_DIV * 3) @(posedge clk);
      mode = 2;
      repeat (FRAME_CLKS) @(posedge clk);
      mode = 0;
      repeat (FRAME_CLKS + 500) @(posedge clk);

      // Asynchronous reset in the middle of a visible line
      target = ((n / FRAME_CLKS) + 1) * FRAME_CLKS + CLK_DIV * (7 * HT + 11) + 2;
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS && !hit; i++) begin
         @(posedge clk);
         #1;
         if (n == target) hit = 1'b1;
      end
      chk("midframe_reach", int'(hit), 1);
      #2 rst = 1'b1;
      q.delete();
      #1;
      chk("async_rst_pixel_x", int'(pixel_x), 0);
      chk("async_rst_pixel_y", int'(pixel_y), 0);
      chk("async_rst_Hsync", int'(Hsync), 1);
      chk("async_rst_Vsync", int'(Vsync), 1);
      chk("async_rst_rgb", int'({vgaRED, vgaGREEN, vgaBLUE}), 0);
      chk("async_rst_pix_tick", int'(pix_tick), 0);
      repeat (5) @(negedge clk);
      #1 rst = 1'b0;

      repeat (FRAME_CLKS + 300) @(posedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- 640x480@60 Hz VGA timing generator feeding display_top; consumes the 100 MHz board clock.
- Derives a 25 MHz pixel-enable tick, runs horizontal/vertical counters, and exposes pixel coordinates to the upstream colour logic.
- Registers the returned 12-bit colour together with Hsync/Vsync, and drives vgaRED/vgaGREEN/vgaBLUE with blanking applied.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz); must be >= 2.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_VIS, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- rgb_in  in  12  colour for (pixel_x, pixel_y), packed {R[11:8], G[7:4], B[3:0]}
- pixel_x  out  10  current h_cnt, 0..799
- pixel_y  out  10  current v_cnt, 0..524
- video_on  out  1  h_cnt < H_VIS and v_cnt < V_VIS (current counters)
- pix_tick  out  1  one-clk pixel enable
- frame_start  out  1  one-clk pulse on the pix_tick where counters wrap to (0,0)
- vgaRED  out  4  red, registered
- vgaGREEN  out  4  green, registered
- vgaBLUE  out  4  blue, registered
- Hsync  out  1  active-low horizontal sync, registered
- Vsync  out  1  active-low vertical sync, registered

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-high. Reset values: div_cnt=0, h_cnt=0, v_cnt=0, pix_tick=0, frame_start=0, colours=0, Hsync=1, Vsync=1.
- pix_tick:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick is high for the one clk where div_cnt==CLK_DIV-1, i.e. every 4th clk.
  - First tick occurs 4 clks after reset release.
- Counters advance only on pix_tick:
  - h_cnt wraps at H_TOTAL-1 (799).
  - On the h wrap, v_cnt increments and wraps at V_TOTAL-1 (524).
  - frame_start=1 on the tick where h=799 and v=524.
  - Full frame = 800*525*4 = 1,680,000 clks.
- Upstream contract: rgb_in must be a function of pixel_x/pixel_y, stable before the next pix_tick edge (CLK_DIV-1 clks of combinational budget).
- Output stage (one pixel period of latency), on each pix_tick edge, using the pre-increment counters:
  - Hsync <= ~(h_cnt in [656,751]).
  - Vsync <= ~(v_cnt in [490,491]).
  - colours <= video_on ? rgb_in : 0.
- Alignment: VGA outputs lag pixel_x/pixel_y by exactly one pixel period, so sync and colour stay mutually aligned. Between ticks, all outputs hold.
- Sync boundaries are derived from the parameters: H sync start = H_VIS+H_FP; V sync start = V_VIS+V_FP.
- rgb_in outside the visible area is ignored; outputs there are forced to 0.
- Reset mid-frame: all outputs return to reset values immediately. The frame restarts at (0,0) with no partial-frame output.

Optional Feature:
- Macro: VGA_PIPE2_EN.
- Defined: an additional pixel-period register stage is added on Hsync, Vsync and video_on only. The colour capture at each tick then takes rgb_in belonging to the previous coordinate, so an upstream with a one-pixel registered lookup (e.g. block-RAM sprite ROM) is supported. Total output latency = 2 pixel periods; the second-stage reset value is Hsync=1, Vsync=1, blank.
- Undefined: single-stage behaviour as described above.

Decomposition:
- Package vga_pkg holds:
  - the timing localparams (H_TOTAL=800, V_TOTAL=525, sync start/end);
  - the RGB12 field slices;
  - the coordinate width (10).
- One sub-module, pixel_tick_gen: the CLK_DIV divider that produces pix_tick, with asynchronous active-high reset. It is reused by later game-tick logic.

Test Plan:
- Reset then release -> pix_tick first high at clk 4 after release, then period 4; Hsync=1, Vsync=1, colours=0 while rst=1.
- Free run one line with rgb_in=12'hFFF -> Hsync low for exactly 96*4=384 clks, starting 657 ticks after line start (h_cnt=656 sampled, +1 latency); line period 3200 clks.
- Free run one frame -> Vsync low for 2 lines (6400 clks), frame_start pulses once per 1,680,000 clks, pixel_y spans 0..524.
- rgb_in=12'hF0A held -> vgaRED=F, vgaGREEN=0, vgaBLUE=A only while delayed video_on; exactly 0 during porches/sync for h 640..799 and v 480..524.
- Assert rst at h_cnt=300, v_cnt=200 -> outputs return to reset values in the same clk asynchronously; after release, counters restart at (0,0).
- With VGA_PIPE2_EN, a one-pixel-delayed ROM model driven from pixel_x -> first visible output colour equals ROM[0]; Hsync falls 2 ticks after h_cnt=656.
